serial_bit_source: RTL and testbench

- Upstream feeder for the serial pattern-detector FSMs in the basics labs.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per enable strobe.
- Produces the `a`/`en` pair a downstream detector consumes: bit_out drives `a`, bit_en drives `en`.
- Strobe rate comes from an internal clock divider; an optional loop mode recirculates the word continuously.

---
 rtl/serial_bit_source_pkg.sv | 21 ++
 rtl/serial_bit_source_strobe_divider.sv | 36 +++
 rtl/serial_bit_source.sv | 94 +++++++++
 tb/tb_serial_bit_source.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bit_source_pkg.sv
// Shared types and sizing helpers for the serial bit source.
package serial_bit_source_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of the strobe divider counter: enough bits to hold DIV-1, never zero.
    function automatic int div_cnt_width(input int div);
        int w;
        w = $clog2(div);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_bit_source_strobe_divider.sv
// Free-running divider that emits one tick every DIV cycles while run is high.
// The counter is held at zero whenever run is low, so the first tick after
// run rises always arrives exactly DIV cycles later.
module strobe_divider
    import serial_bit_source_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int            CW   = div_cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'sd1);
    localparam logic [CW-1:0] STEP = CW'(32'sd1);

    logic [CW-1:0] cnt_r;

    // Count 0..DIV-1 while running, wrap on the tick cycle, clear when stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!run) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + STEP;
        end
    end

    assign tick = run && (cnt_r == LAST);

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial feeder: accepts a word over valid/ready and shifts it
// out MSB-first, one bit per divider strobe, optionally recirculating it.
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int W   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         loop,
    output logic         bit_out,
    output logic         bit_en,
    output logic         busy,
    output logic         done
);

    localparam int            IW       = $clog2(W);
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 32'sd1);
    localparam logic [IW-1:0] IDX_STEP = IW'(32'sd1);

    state_e        state_r;
    logic [W-1:0]  sreg_r;
    logic [W-1:0]  word_r;
    logic [IW-1:0] idx_r;
    logic          run_s;
    logic          tick_s;
    logic          last_s;

    assign run_s  = (state_r == SHIFT);
    assign last_s = (idx_r == IDX_LAST);

    strobe_divider #(
        .DIV (DIV)
    ) u_strobe_divider (
        .clk  (clk),
        .rst  (rst),
        .run  (run_s),
        .tick (tick_s)
    );

    // Load on handshake, advance one bit per strobe, reload or stop after the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sreg_r  <= '0;
            word_r  <= '0;
            idx_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sreg_r  <= in_data;
                        word_r  <= in_data;
                        idx_r   <= '0;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        if (!last_s) begin
                            sreg_r <= {sreg_r[W-2:0], 1'b0};
                            idx_r  <= idx_r + IDX_STEP;
                        end else if (loop) begin
                            // Recirculate with no gap: the divider keeps running.
                            sreg_r <= word_r;
                            idx_r  <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded straight from state; bit_out is forced low when idle.
    assign in_ready = !run_s;
    assign busy     = run_s;
    assign bit_out  = run_s && sreg_r[W-1];
    assign bit_en   = tick_s;
    assign done     = tick_s && last_s && !loop;

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: one instance at DIV=4 and one at DIV=1, both
// tracked every cycle by an arithmetic reference model, plus directed sequences.
module tb_serial_bit_source;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_a [2];
    logic [7:0] in_data_a  [2];
    logic       loop_a     [2];
    logic       rdy0, bsy0, bo0, be0, dn0;
    logic       rdy1, bsy1, bo1, be1, dn1;

    logic       samp_rdy [2];
    logic       samp_bsy [2];
    logic       samp_bo  [2];
    logic       samp_be  [2];
    logic       samp_dn  [2];

    bit         m_active [2];
    int         m_n      [2];
    logic [7:0] m_word   [2];

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    serial_bit_source #(.W(W), .DIV(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(rdy0),
        .in_data(in_data_a[0]), .loop(loop_a[0]), .bit_out(bo0),
        .bit_en(be0), .busy(bsy0), .done(dn0)
    );

    serial_bit_source #(.W(W), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(rdy1),
        .in_data(in_data_a[1]), .loop(loop_a[1]), .bit_out(bo1),
        .bit_en(be1), .busy(bsy1), .done(dn1)
    );

    // ---------------- reference model ----------------
    // m_n counts cycles since the handshake (1 = first cycle); bit k of the
    // stream occupies cycles DIV*k+1 .. DIV*(k+1), strobing on the last one.
    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int kb(input int i);
        return m_active[i] ? (m_n[i] - 1) / dv(i) : 0;
    endfunction

    function automatic logic exp_en(input int i);
        return m_active[i] && ((m_n[i] % dv(i)) == 0);
    endfunction

    function automatic logic exp_bit(input int i);
        return m_active[i] && m_word[i][W - 1 - (kb(i) % W)];
    endfunction

    function automatic logic exp_last(input int i);
        return exp_en(i) && ((kb(i) % W) == W - 1);
    endfunction

    // Advance the model on every clock edge; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] <= 1'b0;
                m_n[i]      <= 0;
                m_word[i]   <= 8'h00;
            end else if (!m_active[i]) begin
                if (in_valid_a[i]) begin
                    m_active[i] <= 1'b1;
                    m_word[i]   <= in_data_a[i];
                    m_n[i]      <= 1;
                end
            end else if (exp_last(i) && !loop_a[i]) begin
                m_active[i] <= 1'b0;
            end else begin
                m_n[i] <= m_n[i] + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        samp_rdy[0] = rdy0; samp_bsy[0] = bsy0; samp_bo[0] = bo0; samp_be[0] = be0; samp_dn[0] = dn0;
        samp_rdy[1] = rdy1; samp_bsy[1] = bsy1; samp_bo[1] = bo1; samp_be[1] = be1; samp_dn[1] = dn1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.in_ready", i), 32'(samp_rdy[i]), 32'(!m_active[i]));
            check($sformatf("u%0d.busy", i),     32'(samp_bsy[i]), 32'(m_active[i]));
            check($sformatf("u%0d.bit_en", i),   32'(samp_be[i]),  32'(exp_en(i)));
            check($sformatf("u%0d.bit_out", i),  32'(samp_bo[i]),  32'(exp_bit(i)));
            check($sformatf("u%0d.done", i),     32'(samp_dn[i]),  32'(exp_last(i) && !loop_a[i]));
        end
    endtask

    // One cycle: compare at the falling edge, then move just past the rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    // Send one non-looped word on the DIV=4 instance and record what comes out.
    task automatic send_word0(input logic [7:0] data, input logic noise,
                              output logic [7:0] stream, output int strobes,
                              output int first_en, output int done_cyc,
                              output int dones, output int ready_hi);
        stream = 8'h00; strobes = 0; first_en = 0; done_cyc = 0; dones = 0; ready_hi = 0;
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = data;
        loop_a[0]     = 1'b0;
        step();
        in_valid_a[0] = noise;
        in_data_a[0]  = noise ? 8'h00 : 8'($urandom);
        for (int c = 1; c <= 33; c++) begin
            if (c == 32) in_valid_a[0] = 1'b0;
            step();
            if (samp_be[0]) begin
                stream = {stream[6:0], samp_bo[0]};
                if (strobes == 0) first_en = c;
                strobes++;
            end
            if (samp_dn[0]) begin
                dones++;
                done_cyc = c;
            end
            if (c <= 32 && samp_rdy[0]) ready_hi++;
            if (c == 33) check("ready_after_word", 32'(samp_rdy[0]), 32'd1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       noise;
        logic [7:0] exp_stream;
        int         exp_first;
        int         exp_done;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [7:0] stream;
        logic [7:0] pat;
        int strobes, first_en, done_cyc, dones, ready_hi, done_at;

        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid_a[i] = 1'b0;
            in_data_a[i]  = 8'h00;
            loop_a[i]     = 1'b0;
        end

        tbl[0] = '{8'hB6, 1'b0, 8'hB6, 4, 32};
        tbl[1] = '{8'h01, 1'b0, 8'h01, 4, 32};
        tbl[2] = '{8'h80, 1'b0, 8'h80, 4, 32};
        tbl[3] = '{8'hB6, 1'b1, 8'hB6, 4, 32};
        tbl[4] = '{8'h5A, 1'b1, 8'h5A, 4, 32};

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Single words, some with in_valid/0x00 noise held during the shift.
        for (int t = 0; t < 5; t++) begin
            send_word0(tbl[t].data, tbl[t].noise, stream, strobes, first_en, done_cyc, dones, ready_hi);
            check($sformatf("tbl%0d.stream", t),   32'(stream),   32'(tbl[t].exp_stream));
            check($sformatf("tbl%0d.strobes", t),  32'(strobes),  32'd8);
            check($sformatf("tbl%0d.first_en", t), 32'(first_en), 32'(tbl[t].exp_first));
            check($sformatf("tbl%0d.done_cyc", t), 32'(done_cyc), 32'(tbl[t].exp_done));
            check($sformatf("tbl%0d.dones", t),    32'(dones),    32'd1);
            check($sformatf("tbl%0d.ready_hi", t), 32'(ready_hi), 32'd0);
        end

        // DIV=1 back-to-back: 0xFF then 0x00 with in_valid held.
        in_valid_a[1] = 1'b1;
        in_data_a[1]  = 8'hFF;
        step();
        in_data_a[1]  = 8'h00;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c == 9) in_valid_a[1] = 1'b0;
            check($sformatf("b2b.en.c%0d", c),   32'(samp_be[1]),  32'(c != 9 && c != 18));
            check($sformatf("b2b.bit.c%0d", c),  32'(samp_bo[1]),  32'(c <= 8));
            check($sformatf("b2b.done.c%0d", c), 32'(samp_dn[1]),  32'(c == 8 || c == 17));
            check($sformatf("b2b.rdy.c%0d", c),  32'(samp_rdy[1]), 32'(c == 9 || c == 18));
        end

        // Loop mode: 0xA5 three times, loop glitched low mid-word 1, dropped in word 3.
        pat = 8'hA5;
        strobes = 0; dones = 0; done_at = 0;
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = pat;
        loop_a[0]     = 1'b1;
        step();
        in_valid_a[0] = 1'b0;
        for (int c = 1; c <= 97; c++) begin
            loop_a[0] = !((c >= 10 && c <= 12) || c >= 70);
            step();
            if (samp_be[0]) begin
                check($sformatf("loop.bit%0d", strobes), 32'(samp_bo[0]), 32'(pat[7 - (strobes % 8)]));
                strobes++;
            end
            if (samp_dn[0]) begin
                dones++;
                done_at = strobes;
            end
        end
        check("loop.strobes", 32'(strobes), 32'd24);
        check("loop.dones", 32'(dones), 32'd1);
        check("loop.done_at", 32'(done_at), 32'd24);
        check("loop.ready_end", 32'(samp_rdy[0]), 32'd1);
        loop_a[0] = 1'b0;

        // Async reset after the third strobe of 0xB6, with no clock edge during it.
        strobes = 0;
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 8'hB6;
        step();
        in_valid_a[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (samp_be[0]) strobes++;
        end
        check("rst.pre_strobes", 32'(strobes), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("rst.in_ready", 32'(rdy0), 32'd1);
        check("rst.busy",     32'(bsy0), 32'd0);
        check("rst.bit_out",  32'(bo0),  32'd0);
        check("rst.bit_en",   32'(be0),  32'd0);
        check("rst.done",     32'(dn0),  32'd0);
        #1 rst = 1'b0;
        strobes = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (samp_be[0]) strobes++;
            if (samp_dn[0]) dones++;
        end
        check("rst.post_strobes", 32'(strobes), 32'd0);
        check("rst.post_dones",   32'(dones),   32'd0);
        send_word0(8'h80, 1'b0, stream, strobes, first_en, done_cyc, dones, ready_hi);
        check("rst.new_stream",   32'(stream),   32'h80);
        check("rst.new_first_en", 32'(first_en), 32'd4);
        check("rst.new_done_cyc", 32'(done_cyc), 32'd32);

        // Random traffic on both instances against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid_a[i] = ($urandom_range(0, 3) == 0);
                in_data_a[i]  = 8'($urandom);
                loop_a[i]     = ($urandom_range(0, 5) == 0);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            in_valid_a[i] = 1'b0;
            loop_a[i]     = 1'b0;
        end
        for (int n = 0; n < 40; n++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
